// File: rtl/multicycle_control.sv
// multicycle_control: sequenced FETCH/DECODE/EXEC/MEM/WB controller for the
// RISC-KGP datapath. It waits on a memory handshake, honours a stall (hold)
// input, and traps on illegal opcodes or on memory requests that go unacked
// for too long.
// Optional build macro: MC_CTRL_PERF_EN adds cycle_cnt/instr_cnt counters.
module multicycle_control #(
   parameter int OPC_W        = 5,
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OPC_W-1:0] opcode,
   input  logic             hold,
   input  logic             mem_ack,
   output logic [2:0]       state,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_req,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_reg,
   output logic             write_data,
   output logic             reg_write,
   output logic [1:0]       reg_dest,
   output logic [1:0]       alu_src,
   output logic [1:0]       alu_op,
   output logic [1:0]       branch,
   output logic             instr_done,
   output logic             trap,
   output logic [1:0]       trap_cause
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } stateT;

   // Wide enough to hold MEM_WAIT_MAX itself.
   localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
   // Count value seen on the last tolerated unacked cycle; the next
   // increment would reach MEM_WAIT_MAX, so that cycle raises the trap.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);
   localparam logic [OPC_W-1:0]  OPC_MAX   = OPC_W'(9);

   stateT             curState, nextState;
   logic [OPC_W-1:0]  opQ;
   logic [WAIT_W-1:0] waitCnt;
   logic [1:0]        causeNext;
   logic              memPhase;

   assign state    = curState;
   // States in which a memory request is outstanding.
   assign memPhase = (curState == S_FETCH) || (curState == S_MEM);

   // State, latched opcode and trap flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         curState   <= S_FETCH;
         opQ        <= '0;
         trap       <= 1'b0;
         trap_cause <= 2'b00;
      end else if (!hold) begin
         curState <= nextState;
         if (curState == S_DECODE) opQ <= opcode;
         if (nextState == S_TRAP && curState != S_TRAP) begin
            trap       <= 1'b1;
            trap_cause <= causeNext;
         end
      end
   end

   // Memory wait counter: counts unacked request cycles, frozen by hold,
   // cleared on ack or whenever the state moves on.
   always_ff @(posedge clk) begin
      if (rst)                                     waitCnt <= '0;
      else if (hold)                               waitCnt <= waitCnt;
      else if (mem_ack || nextState != curState)   waitCnt <= '0;
      else if (memPhase)                           waitCnt <= waitCnt + 1'b1;
   end

   // Next state and Moore strobes; everything is silent in rst and hold cycles.
   always_comb begin
      nextState     = curState;
      causeNext     = 2'b00;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_req       = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_reg       = 1'b0;
      write_data    = 1'b0;
      reg_write     = 1'b0;
      reg_dest      = 2'b00;
      alu_src       = 2'b00;
      alu_op        = 2'b00;
      branch        = 2'b00;
      instr_done    = 1'b0;
      if (!rst && !hold) begin
         case (curState)
            S_FETCH: begin
               mem_req  = 1'b1;
               mem_read = 1'b1;
               if (mem_ack) begin
                  ir_write  = 1'b1;
                  pc_write  = 1'b1;
                  nextState = S_DECODE;
               end else if (waitCnt == WAIT_LAST) begin
                  nextState = S_TRAP;
                  causeNext = 2'b10;
               end
            end
            S_DECODE: begin
               if (opcode > OPC_MAX) begin
                  nextState = S_TRAP;
                  causeNext = 2'b01;
               end else begin
                  nextState = S_EXEC;
               end
            end
            S_EXEC: begin
               case (int'(opQ))
                  0:       begin alu_src = 2'b00; alu_op = 2'b01; nextState = S_WB; end
                  1:       begin alu_src = 2'b11; alu_op = 2'b01; nextState = S_WB; end
                  2, 3:    begin alu_src = 2'b01; alu_op = 2'b00; nextState = S_MEM; end
                  4:       begin alu_src = 2'b01; alu_op = 2'b00; nextState = S_WB; end
                  5:       begin alu_src = 2'b01; alu_op = 2'b10; nextState = S_WB; end
                  6, 8:    begin
                     branch = 2'b11; pc_write_cond = 1'b1;
                     instr_done = 1'b1; nextState = S_FETCH;
                  end
                  7:       begin
                     branch = 2'b01; pc_write_cond = 1'b1;
                     instr_done = 1'b1; nextState = S_FETCH;
                  end
                  9:       begin branch = 2'b11; pc_write_cond = 1'b1; nextState = S_WB; end
                  default: nextState = S_TRAP;
               endcase
            end
            S_MEM: begin
               mem_req   = 1'b1;
               i_or_d    = 1'b1;
               mem_read  = (opQ == OPC_W'(2));
               mem_write = (opQ == OPC_W'(3));
               if (mem_ack) begin
                  if (opQ == OPC_W'(2)) begin
                     nextState = S_WB;
                  end else begin
                     instr_done = 1'b1;
                     nextState  = S_FETCH;
                  end
               end else if (waitCnt == WAIT_LAST) begin
                  nextState = S_TRAP;
                  causeNext = 2'b10;
               end
            end
            S_WB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
               nextState  = S_FETCH;
               if (opQ == OPC_W'(2)) begin
                  mem_reg  = 1'b1;
                  reg_dest = 2'b01;
               end else if (opQ == OPC_W'(9)) begin
                  write_data = 1'b1;
                  reg_dest   = 2'b10;
               end
            end
            S_TRAP:  nextState = S_TRAP;
            default: nextState = S_TRAP;
         endcase
      end
   end

`ifdef MC_CTRL_PERF_EN
   // Performance counters: live cycles outside TRAP and retired instructions.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (curState != S_TRAP) cycle_cnt <= cycle_cnt + 1'b1;
         if (instr_done)         instr_cnt <= instr_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-class sequencing, memory wait,
// hold, mid-instruction reset, timeout and illegal-opcode traps.
module tb_multicycle_control;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] opcode = '0;
   logic       hold = 1'b0;
   logic       memAck = 1'b0;
   logic [2:0] state;
   logic       irWrite, pcWrite, pcWriteCond, iOrD, memReq, memRead, memWrite;
   logic       memReg, writeData, regWrite, instrDone, trap;
   logic [1:0] regDest, aluSrc, aluOp, branch, trapCause;
`ifdef MC_CTRL_PERF_EN
   logic [31:0] cycleCnt, instrCnt;
`endif
   int checks = 0;
   int errors = 0;

   multicycle_control #(.OPC_W(5), .MEM_WAIT_MAX(15), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .hold(hold), .mem_ack(memAck),
      .state(state), .ir_write(irWrite), .pc_write(pcWrite),
      .pc_write_cond(pcWriteCond), .i_or_d(iOrD), .mem_req(memReq),
      .mem_read(memRead), .mem_write(memWrite), .mem_reg(memReg),
      .write_data(writeData), .reg_write(regWrite), .reg_dest(regDest),
      .alu_src(aluSrc), .alu_op(aluOp), .branch(branch),
      .instr_done(instrDone), .trap(trap), .trap_cause(trapCause)
`ifdef MC_CTRL_PERF_EN
      , .cycle_cnt(cycleCnt), .instr_cnt(instrCnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply inputs shortly after the edge, then let the comb outputs settle.
   task automatic setin(input logic a, input logic h);
      memAck = a;
      hold   = h;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chkS(input string tag, input logic [2:0] st, input logic dn, input logic rw);
      chk({tag, ".state"}, 32'(state), 32'(st));
      chk({tag, ".done"}, 32'(instrDone), 32'(dn));
      chk({tag, ".regw"}, 32'(regWrite), 32'(rw));
   endtask

   initial begin
      // Reset
      tick; tick;
      setin(1, 0);
      chk("rst.state", 32'(state), 0);
      chk("rst.memreq", 32'(memReq), 0);
      chk("rst.trap", 32'(trap), 0);
      chk("rst.cause", 32'(trapCause), 0);

      // R-type, zero-wait: 0,1,2,4,0
      rst = 1'b0; opcode = 5'd0;
      setin(1, 0); chkS("A0", 0, 0, 0);
      chk("A0.memreq", 32'(memReq), 1); chk("A0.irw", 32'(irWrite), 1);
      chk("A0.pcw", 32'(pcWrite), 1);   chk("A0.iord", 32'(iOrD), 0);
      chk("A0.memrd", 32'(memRead), 1);
      tick; setin(1, 0); chkS("A1", 1, 0, 0);
      tick; setin(1, 0); chkS("A2", 2, 0, 0);
      chk("A2.alusrc", 32'(aluSrc), 0); chk("A2.aluop", 32'(aluOp), 1);
      tick; setin(1, 0); chkS("A3", 4, 1, 1);
      tick; setin(1, 0); chkS("A4", 0, 0, 0);

      // lw with three unacked MEM cycles: 8 cycles total
      opcode = 5'd2;
      tick; setin(1, 0); chkS("B1", 1, 0, 0);
      tick; setin(1, 0); chkS("B2", 2, 0, 0);
      chk("B2.alusrc", 32'(aluSrc), 1); chk("B2.aluop", 32'(aluOp), 0);
      tick;
      for (int i = 0; i < 3; i++) begin
         setin(0, 0); chkS("Bw", 3, 0, 0);
         chk("Bw.memrd", 32'(memRead), 1); chk("Bw.iord", 32'(iOrD), 1);
         chk("Bw.memwr", 32'(memWrite), 0); chk("Bw.memreq", 32'(memReq), 1);
         tick;
      end
      setin(1, 0); chkS("B6", 3, 0, 0); chk("B6.memrd", 32'(memRead), 1);
      tick; setin(1, 0); chkS("B7", 4, 1, 1);
      chk("B7.memreg", 32'(memReg), 1); chk("B7.rdst", 32'(regDest), 1);
      tick; setin(1, 0); chkS("B8", 0, 0, 0);

      // sw: MEM writes only, then FETCH without reg_write
      opcode = 5'd3;
      tick; tick; tick;
      setin(1, 0); chkS("C3", 3, 1, 0);
      chk("C3.memwr", 32'(memWrite), 1); chk("C3.memrd", 32'(memRead), 0);
      tick; setin(1, 0); chkS("C4", 0, 0, 0);

      // bal: EXEC branch=11, WB write_data and reg_dest=10
      opcode = 5'd9;
      tick; tick; setin(1, 0); chkS("D2", 2, 0, 0);
      chk("D2.br", 32'(branch), 3); chk("D2.pwc", 32'(pcWriteCond), 1);
      tick; setin(1, 0); chkS("D3", 4, 1, 1);
      chk("D3.wdata", 32'(writeData), 1); chk("D3.rdst", 32'(regDest), 2);
      chk("D3.memreg", 32'(memReg), 0);
      tick; setin(1, 0); chkS("D4", 0, 0, 0);

      // br: 3-cycle instruction, branch=01
      opcode = 5'd7;
      tick; tick; setin(1, 0); chkS("G2", 2, 1, 0);
      chk("G2.br", 32'(branch), 1); chk("G2.pwc", 32'(pcWriteCond), 1);
      tick; setin(1, 0); chkS("G3", 0, 0, 0);

      // hold: ack ignored in FETCH, EXEC frozen for 2 cycles with no strobes
      opcode = 5'd0;
      setin(1, 1); chk("H0.memreq", 32'(memReq), 0); chk("H0.irw", 32'(irWrite), 0);
      tick; setin(1, 0); chkS("H1", 0, 0, 0);
      tick; tick;
      for (int i = 0; i < 2; i++) begin
         setin(1, 1); chkS("Hh", 2, 0, 0); chk("Hh.aluop", 32'(aluOp), 0);
         tick;
      end
      setin(1, 0); chkS("H4", 2, 0, 0); chk("H4.aluop", 32'(aluOp), 1);
      tick; setin(1, 0); chkS("H5", 4, 1, 1);
      tick; setin(1, 0); chkS("H6", 0, 0, 0);

      // reset in the middle of a sw MEM phase suppresses the write
      opcode = 5'd3;
      tick; tick; tick;
      setin(0, 0); chk("R0.memwr", 32'(memWrite), 1);
      rst = 1'b1; #1;
      chk("R1.memwr", 32'(memWrite), 0); chk("R1.memreq", 32'(memReq), 0);
      tick; rst = 1'b0;
      setin(0, 0); chkS("R2", 0, 0, 0);

      // fetch timeout: trap exactly 15 cycles after entering FETCH
      for (int i = 0; i < 15; i++) begin
         setin(0, 0); chk("T.state", 32'(state), 0); chk("T.memreq", 32'(memReq), 1);
         tick;
      end
      setin(0, 0);
      chk("T.trapst", 32'(state), 7); chk("T.trap", 32'(trap), 1);
      chk("T.cause", 32'(trapCause), 2); chk("T.memreq", 32'(memReq), 0);
      rst = 1'b1; tick; rst = 1'b0;

      // illegal opcode traps from DECODE and stays there
      opcode = 5'd12;
      setin(1, 0); tick; tick;
      setin(1, 0); chk("I.state", 32'(state), 7);
      chk("I.trap", 32'(trap), 1); chk("I.cause", 32'(trapCause), 1);
      tick; tick; setin(1, 0);
      chk("I.stay", 32'(state), 7); chk("I.memreq", 32'(memReq), 0);
      chk("I.irw", 32'(irWrite), 0);

`ifdef MC_CTRL_PERF_EN
      // three back-to-back R-type instructions
      rst = 1'b1; tick; rst = 1'b0; opcode = 5'd0;
      setin(1, 0);
      for (int i = 0; i < 12; i++) tick;
      #1;
      chk("P.instr", instrCnt, 3); chk("P.cycle", cycleCnt, 12);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
